// File: rtl/kem_cmd_arbiter_pkg.sv
// Shared types and constants for the KEM command arbiter and the kyber_top engine interface.
//   OP_W / SLOT_W / PARAM_W : engine command field widths
//   GID_W                   : grant index width (supports up to 8 requesters)
//   WD_W                    : watchdog counter width
//   state_t                 : arbiter FSM encoding
//   cmd_t                   : latched engine command payload
//   rr_next()               : round-robin successor of a requester index
package kem_cmd_arbiter_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned PARAM_W = 4;
    localparam int unsigned GID_W   = 3;
    localparam int unsigned WD_W    = 16;

    // Micro-op codes understood by kyber_top
    localparam logic [OP_W-1:0] OP_NOP        = 4'h0;
    localparam logic [OP_W-1:0] OP_NTT        = 4'h1;
    localparam logic [OP_W-1:0] OP_INTT       = 4'h2;
    localparam logic [OP_W-1:0] OP_PMUL       = 4'h3;
    localparam logic [OP_W-1:0] OP_PADD       = 4'h4;
    localparam logic [OP_W-1:0] OP_PSUB       = 4'h5;
    localparam logic [OP_W-1:0] OP_CBD        = 4'h6;
    localparam logic [OP_W-1:0] OP_SAMPLE     = 4'h7;
    localparam logic [OP_W-1:0] OP_COMPRESS   = 4'h8;
    localparam logic [OP_W-1:0] OP_DECOMPRESS = 4'h9;
    localparam logic [OP_W-1:0] OP_COPY       = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [SLOT_W-1:0]  slot_a;
        logic [SLOT_W-1:0]  slot_b;
        logic [PARAM_W-1:0] param;
    } cmd_t;

    // (idx + 1) mod n_req without a divider
    function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] idx,
                                                 input int unsigned      n_req);
        if (32'(idx) + 32'd1 >= n_req) begin
            return '0;
        end
        return idx + GID_W'(1);
    endfunction

endpackage

// File: rtl/kem_cmd_arbiter_rr.sv
// Combinational rotate-priority picker: first set bit of req at or after ptr, wrapping.
//   req       : request vector
//   ptr       : starting index (must be < N_REQ)
//   gnt_oh_c  : one-hot winner
//   gnt_idx_c : winner index
//   any_c     : at least one request present
module kem_cmd_arbiter_rr
    import kem_cmd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GID_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh_c,
    output logic [GID_W-1:0] gnt_idx_c,
    output logic             any_c
);

    localparam int unsigned POS_W = GID_W + 1;

    logic [POS_W-1:0] pos;

    // Walk positions ptr, ptr+1, ... (mod N_REQ); the first requester hit wins
    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        pos       = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            pos = {1'b0, ptr} + POS_W'(k);
            if (pos >= POS_W'(N_REQ)) begin
                pos = pos - POS_W'(N_REQ);
            end
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!any_c && req[i] && (pos == POS_W'(i))) begin
                    any_c        = 1'b1;
                    gnt_oh_c[i]  = 1'b1;
                    gnt_idx_c    = GID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/kem_cmd_arbiter.sv
// Shares the kyber_top micro-op engine between N_REQ command requesters.
// Round-robin grant per micro-op; a requester holding req_lock keeps the engine
// across a sequence. Host bank I/O is only enabled while the engine is idle.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/op/slot_a/b/param/lock : per-requester command inputs (packed by index)
//   req_ready, req_done      : per-requester accept / finish pulses
//   grant_id, grant_busy     : current owner and ownership flag
//   cmd_op/slot_a/slot_b/param, cmd_start, cmd_done : engine command interface
//   host_en                  : host polynomial I/O permitted
//   err_timeout, err_clr     : sticky watchdog error and its clear
module kem_cmd_arbiter
    import kem_cmd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [OP_W*N_REQ-1:0]      req_op,
    input  logic [SLOT_W*N_REQ-1:0]    req_slot_a,
    input  logic [SLOT_W*N_REQ-1:0]    req_slot_b,
    input  logic [PARAM_W*N_REQ-1:0]   req_param,
    input  logic [N_REQ-1:0]           req_lock,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           req_done,
    output logic [GID_W-1:0]           grant_id,
    output logic                       grant_busy,
    output logic [OP_W-1:0]            cmd_op,
    output logic [SLOT_W-1:0]          cmd_slot_a,
    output logic [SLOT_W-1:0]          cmd_slot_b,
    output logic [PARAM_W-1:0]         cmd_param,
    output logic                       cmd_start,
    input  logic                       cmd_done,
    output logic                       host_en,
    output logic                       err_timeout,
    input  logic                       err_clr
);

    state_t            state_q, state_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    cmd_t              cmd_q;
    logic [WD_W-1:0]   wd_cnt_q;

    logic [N_REQ-1:0]  arb_oh_c;
    logic [GID_W-1:0]  arb_idx_c;
    logic              arb_any_c;

    logic [N_REQ-1:0]  own_oh_c;
    logic              own_valid_c;
    logic              own_lock_c;
    logic [N_REQ-1:0]  sel_oh_c;
    logic [GID_W-1:0]  sel_idx_c;
    cmd_t              sel_cmd_c;
    logic              expire_c;

    logic              accept_c;
    logic              finish_c;
    logic              timeout_c;
    logic [N_REQ-1:0]  ready_d;
    logic [N_REQ-1:0]  done_d;
    logic              start_d;
    logic              busy_d;
    logic              host_en_d;
    logic              err_d;

    kem_cmd_arbiter_rr #(
        .N_REQ     (N_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt_oh_c  (arb_oh_c),
        .gnt_idx_c (arb_idx_c),
        .any_c     (arb_any_c)
    );

    // Current owner as a one-hot, plus its valid / lock inputs
    always_comb begin
        own_oh_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            own_oh_c[i] = (grant_id == GID_W'(i));
        end
    end

    assign own_valid_c = |(req_valid & own_oh_c);
    assign own_lock_c  = |(req_lock & own_oh_c);

    // In IDLE the arbiter picks; in HOLD only the owner can be accepted
    assign sel_oh_c  = (state_q == ST_IDLE) ? arb_oh_c  : own_oh_c;
    assign sel_idx_c = (state_q == ST_IDLE) ? arb_idx_c : grant_id;

    // Mux the selected requester's fields (one-hot AND-OR)
    always_comb begin
        sel_cmd_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (sel_oh_c[i]) begin
                sel_cmd_c.op     = sel_cmd_c.op     | req_op[OP_W*i +: OP_W];
                sel_cmd_c.slot_a = sel_cmd_c.slot_a | req_slot_a[SLOT_W*i +: SLOT_W];
                sel_cmd_c.slot_b = sel_cmd_c.slot_b | req_slot_b[SLOT_W*i +: SLOT_W];
                sel_cmd_c.param  = sel_cmd_c.param  | req_param[PARAM_W*i +: PARAM_W];
            end
        end
    end

    // Counter counts WAIT cycles from 0, so expiry lands on the TIMEOUT-th WAIT cycle
    assign expire_c = (TIMEOUT != 0) && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    state_d = own_lock_c ? ST_HOLD : ST_IDLE;
                end else if (expire_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (own_valid_c) begin
                    state_d = ST_ISSUE;
                end else if (!own_lock_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered outputs and pointer
    always_comb begin
        accept_c  = 1'b0;
        finish_c  = 1'b0;
        timeout_c = 1'b0;
        ptr_d     = ptr_q;
        ready_d   = '0;
        done_d    = '0;
        start_d   = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        host_en_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        err_d     = err_timeout;
        case (state_q)
            ST_IDLE: begin
                accept_c = arb_any_c;
            end
            ST_ISSUE: begin
                start_d = 1'b1;
            end
            ST_WAIT: begin
                // A done on the expiry cycle wins over the watchdog
                if (cmd_done) begin
                    finish_c = 1'b1;
                    if (!own_lock_c) begin
                        ptr_d = rr_next(grant_id, N_REQ);
                    end
                end else if (expire_c) begin
                    finish_c  = 1'b1;
                    timeout_c = 1'b1;
                    ptr_d     = rr_next(grant_id, N_REQ);
                end
            end
            ST_HOLD: begin
                if (own_valid_c) begin
                    accept_c = 1'b1;
                end else if (!own_lock_c) begin
                    ptr_d = rr_next(grant_id, N_REQ);
                end
            end
            default: begin
            end
        endcase
        if (accept_c) begin
            ready_d = sel_oh_c;
        end
        if (finish_c) begin
            done_d = own_oh_c;
        end
        // A new timeout beats a simultaneous clear
        if (timeout_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Output, command latch, pointer and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cmd_q       <= '0;
            grant_id    <= '0;
            wd_cnt_q    <= '0;
            req_ready   <= '0;
            req_done    <= '0;
            cmd_start   <= 1'b0;
            grant_busy  <= 1'b0;
            host_en     <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            req_ready   <= ready_d;
            req_done    <= done_d;
            cmd_start   <= start_d;
            grant_busy  <= busy_d;
            host_en     <= host_en_d;
            err_timeout <= err_d;
            if (accept_c) begin
                cmd_q    <= sel_cmd_c;
                grant_id <= sel_idx_c;
            end
            if (state_q == ST_ISSUE) begin
                wd_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
        end
    end

    assign cmd_op     = cmd_q.op;
    assign cmd_slot_a = cmd_q.slot_a;
    assign cmd_slot_b = cmd_q.slot_b;
    assign cmd_param  = cmd_q.param;

endmodule

// File: tb/tb_kem_cmd_arbiter.sv
// Directed bench for kem_cmd_arbiter (3 requesters, watchdog of 20 cycles).
module tb_kem_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [11:0] req_op;
    logic [14:0] req_slot_a;
    logic [14:0] req_slot_b;
    logic [11:0] req_param;
    logic [2:0]  req_lock = '0;
    logic [2:0]  req_ready;
    logic [2:0]  req_done;
    logic [2:0]  grant_id;
    logic        grant_busy;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_slot_a;
    logic [4:0]  cmd_slot_b;
    logic [3:0]  cmd_param;
    logic        cmd_start;
    logic        cmd_done = 1'b0;
    logic        host_en;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    // Fixed per-requester command fields
    logic [3:0] r_op [3] = '{4'h3, 4'h5, 4'hA};
    logic [4:0] r_sa [3] = '{5'd4, 5'd1, 5'd30};
    logic [4:0] r_sb [3] = '{5'd7, 5'd2, 5'd31};
    logic [3:0] r_pa [3] = '{4'd2, 4'd9, 4'd15};

    assign req_op     = {r_op[2], r_op[1], r_op[0]};
    assign req_slot_a = {r_sa[2], r_sa[1], r_sa[0]};
    assign req_slot_b = {r_sb[2], r_sb[1], r_sb[0]};
    assign req_param  = {r_pa[2], r_pa[1], r_pa[0]};

    always #5 clk = ~clk;

    kem_cmd_arbiter #(
        .N_REQ      (3),
        .TIMEOUT    (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_slot_a  (req_slot_a),
        .req_slot_b  (req_slot_b),
        .req_param   (req_param),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .grant_id    (grant_id),
        .grant_busy  (grant_busy),
        .cmd_op      (cmd_op),
        .cmd_slot_a  (cmd_slot_a),
        .cmd_slot_b  (cmd_slot_b),
        .cmd_param   (cmd_param),
        .cmd_start   (cmd_start),
        .cmd_done    (cmd_done),
        .host_en     (host_en),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic       done;
        logic [2:0] e_ready;
        logic [2:0] e_done;
        logic       e_start;
        logic       e_busy;
        logic       e_host;
        logic [2:0] e_gid;
        logic [3:0] e_op;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [2:0] v, input logic d,
                       input logic [2:0] ery, input logic [2:0] edn, input logic est,
                       input logic ebs, input logic ehs, input logic [2:0] egd,
                       input logic [3:0] eop);
        vec_t x;
        x.rst = r; x.valid = v; x.done = d;
        x.e_ready = ery; x.e_done = edn; x.e_start = est;
        x.e_busy = ebs; x.e_host = ehs; x.e_gid = egd; x.e_op = eop;
        tbl.push_back(x);
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = '0; req_lock = '0; cmd_done = 1'b0; err_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Wait for grant to g, check command fields, finish the op after 'delay' WAIT cycles
    task automatic do_op(input int g, input int delay, input logic [2:0] v_after,
                         input logic [2:0] l_after);
        int n;
        n = 0;
        while (req_ready == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("op g%0d ready", g), 32'(req_ready), 32'(1 << g));
        check($sformatf("op g%0d grant_id", g), 32'(grant_id), 32'(g));
        check($sformatf("op g%0d host_en issue", g), 32'(host_en), 32'd0);
        req_valid = v_after;
        req_lock  = l_after;
        tick();
        check($sformatf("op g%0d cmd_start", g), 32'(cmd_start), 32'd1);
        check($sformatf("op g%0d cmd_op", g), 32'(cmd_op), 32'(r_op[g]));
        check($sformatf("op g%0d cmd_slot_a", g), 32'(cmd_slot_a), 32'(r_sa[g]));
        check($sformatf("op g%0d cmd_slot_b", g), 32'(cmd_slot_b), 32'(r_sb[g]));
        check($sformatf("op g%0d cmd_param", g), 32'(cmd_param), 32'(r_pa[g]));
        repeat (delay) tick();
        check($sformatf("op g%0d start single", g), 32'(cmd_start), 32'd0);
        check($sformatf("op g%0d cmd_op stable", g), 32'(cmd_op), 32'(r_op[g]));
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check($sformatf("op g%0d req_done", g), 32'(req_done), 32'(1 << g));
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Single req0 op, spurious done in IDLE, req2 op cut by reset, pointer reset
        add(1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h0);
        add(0, 3'b001, 0, 3'b001, 3'b000, 0, 1, 0, 3'd0, 4'h3);
        add(0, 3'b000, 0, 3'b000, 3'b000, 1, 1, 0, 3'd0, 4'h3);
        for (int i = 0; i < 9; i++) begin
            add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, 3'd0, 4'h3);
        end
        add(0, 3'b000, 1, 3'b000, 3'b001, 0, 0, 0, 3'd0, 4'h3);
        add(0, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h3);
        add(0, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h3);
        add(0, 3'b100, 0, 3'b100, 3'b000, 0, 1, 0, 3'd2, 4'hA);
        add(0, 3'b000, 0, 3'b000, 3'b000, 1, 1, 0, 3'd2, 4'hA);
        add(0, 3'b000, 0, 3'b000, 3'b000, 0, 1, 0, 3'd2, 4'hA);
        add(1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h0);
        add(0, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h0);
        add(0, 3'b101, 0, 3'b001, 3'b000, 0, 1, 0, 3'd0, 4'h3);
        add(1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 1, 3'd0, 4'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            req_valid = tbl[i].valid;
            cmd_done  = tbl[i].done;
            tick();
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            check($sformatf("row%0d req_done", i), 32'(req_done), 32'(tbl[i].e_done));
            check($sformatf("row%0d cmd_start", i), 32'(cmd_start), 32'(tbl[i].e_start));
            check($sformatf("row%0d grant_busy", i), 32'(grant_busy), 32'(tbl[i].e_busy));
            check($sformatf("row%0d host_en", i), 32'(host_en), 32'(tbl[i].e_host));
            check($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].e_gid));
            check($sformatf("row%0d cmd_op", i), 32'(cmd_op), 32'(tbl[i].e_op));
            check($sformatf("row%0d err_timeout", i), 32'(err_timeout), 32'd0);
        end
        cmd_done = 1'b0;

        // Round robin with all requesters valid
        reset_dut();
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            do_op(k % 3, 2, 3'b111, 3'b000);
        end

        // Locked sequence by req1 with others pending
        reset_dut();
        req_valid = 3'b010;
        req_lock  = 3'b010;
        do_op(1, 3, 3'b101, 3'b010);
        check("hold busy", 32'(grant_busy), 32'd1);
        check("hold host_en", 32'(host_en), 32'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("hold spurious done", 32'(req_done), 32'd0);
        check("hold no ready", 32'(req_ready), 32'd0);
        tick();
        check("hold still busy", 32'(grant_busy), 32'd1);
        check("hold owner", 32'(grant_id), 32'd1);
        req_valid = 3'b111;
        do_op(1, 2, 3'b111, 3'b010);
        do_op(1, 2, 3'b111, 3'b010);
        do_op(1, 2, 3'b101, 3'b000);
        do_op(2, 2, 3'b101, 3'b000);

        // Watchdog expiry, sticky flag and clear
        reset_dut();
        req_valid = 3'b001;
        tick();
        check("to ready", 32'(req_ready), 32'b001);
        req_valid = 3'b000;
        tick();
        check("to start", 32'(cmd_start), 32'd1);
        repeat (19) tick();
        check("to err before", 32'(err_timeout), 32'd0);
        check("to busy before", 32'(grant_busy), 32'd1);
        check("to done before", 32'(req_done), 32'd0);
        tick();
        check("to err set", 32'(err_timeout), 32'd1);
        check("to req_done", 32'(req_done), 32'b001);
        check("to busy off", 32'(grant_busy), 32'd0);
        tick();
        check("to err sticky", 32'(err_timeout), 32'd1);
        check("to host_en back", 32'(host_en), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to err cleared", 32'(err_timeout), 32'd0);

        // Done on the expiry cycle counts as done
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        tick();
        repeat (19) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("edge req_done", 32'(req_done), 32'b001);
        check("edge no err", 32'(err_timeout), 32'd0);

        // Clear held across a new timeout: set wins
        err_clr   = 1'b1;
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        tick();
        repeat (20) tick();
        check("setwins err", 32'(err_timeout), 32'd1);
        check("setwins req_done", 32'(req_done), 32'b001);
        tick();
        check("setwins then clear", 32'(err_timeout), 32'd0);
        err_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
